// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I encoding definitions: opcodes, instruction formats and
// loader FSM states. Also imported by the main control-unit decoder.
package instr_encoder_loader_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ld_state_e;

    // True when bits [31:lsb] of v are all equal, i.e. v fits a signed
    // field whose sign bit sits at position lsb.
    function automatic logic sext_ok(input logic [31:0] v, input int lsb);
        logic all1;
        logic all0;
        all1 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb) begin
                all1 = all1 & v[i];
                all0 = all0 & ~v[i];
            end
        end
        return all1 | all0;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational RV32I field packer: fields -> {machine word, format, illegal}.
// Illegal covers unsupported opcodes and immediates that do not fit the format.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  f3_i,
    input  logic        f7b5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output fmt_e        fmt_o,
    output logic        illegal_o
);

    logic is_shift;

    // Shifts are the only I-type encodings that carry funct7 bit 5.
    assign is_shift = (op_i == OP_I_ALU) && ((f3_i == 3'b001) || (f3_i == 3'b101));

    // Format select, bit scatter and immediate range check.
    always_comb begin
        word_o    = 32'h0;
        fmt_o     = FMT_R;
        illegal_o = 1'b0;
        case (op_i)
            OP_R: begin
                fmt_o  = FMT_R;
                word_o = {1'b0, f7b5_i, 5'b0, rs2_i, rs1_i, f3_i, rd_i, op_i};
            end
            OP_I_ALU, OP_LOAD, OP_JALR: begin
                fmt_o     = FMT_I;
                illegal_o = !sext_ok(imm_i, 11);
                if (is_shift)
                    word_o = {1'b0, f7b5_i, 5'b0, imm_i[4:0], rs1_i, f3_i, rd_i, op_i};
                else
                    word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, op_i};
            end
            OP_STORE: begin
                fmt_o     = FMT_S;
                illegal_o = !sext_ok(imm_i, 11);
                word_o    = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], op_i};
            end
            OP_BRANCH: begin
                fmt_o     = FMT_B;
                illegal_o = !sext_ok(imm_i, 12) || imm_i[0];
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                             imm_i[4:1], imm_i[11], op_i};
            end
            OP_LUI: begin
                fmt_o     = FMT_U;
                illegal_o = (imm_i[11:0] != 12'h0);
                word_o    = {imm_i[31:12], rd_i, op_i};
            end
            OP_JAL: begin
                fmt_o     = FMT_J;
                illegal_o = !sext_ok(imm_i, 20) || imm_i[0];
                word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: takes decoded fields over valid/ready, packs them into
// RV32I words and writes them sequentially to instruction memory, holding
// the core in reset until a complete error-free load has finished.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int               MEM_WORDS = 64,
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    localparam int              CW        = $clog2(MEM_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fld_valid,
    output logic              fld_ready,
    input  logic [6:0]        fld_op,
    input  logic [4:0]        fld_rd,
    input  logic [4:0]        fld_rs1,
    input  logic [4:0]        fld_rs2,
    input  logic [2:0]        fld_f3,
    input  logic              fld_f7b5,
    input  logic [31:0]       fld_imm,
    input  logic              fld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [CW-1:0]     word_count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic              cpu_rst_n
);

    ld_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              eill_q, eill_d;
    logic              eovf_q, eovf_d;

    logic [31:0] pk_word;
    fmt_e        pk_fmt;
    logic        pk_illegal;
    logic        accept;
    logic        full_next;
    logic        unused_fmt;

    instr_field_packer u_packer (
        .op_i      (fld_op),
        .rd_i      (fld_rd),
        .rs1_i     (fld_rs1),
        .rs2_i     (fld_rs2),
        .f3_i      (fld_f3),
        .f7b5_i    (fld_f7b5),
        .imm_i     (fld_imm),
        .word_o    (pk_word),
        .fmt_o     (pk_fmt),
        .illegal_o (pk_illegal)
    );

    // Format is only consumed by the main decoder; the loader needs the word.
    assign unused_fmt = ^pk_fmt;

    // The write in flight will fill the last slot: take no further bundle.
    assign full_next = we_q && (cnt_q == CW'(MEM_WORDS - 1));
    assign fld_ready = (state_q == ST_LOAD) && !full_next;
    assign accept    = fld_valid && fld_ready;

    // Next-state: FSM, write register, address/count advance, sticky errors.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        eill_d  = eill_q;
        eovf_d  = eovf_q;

        // A write completes on every edge where it is presented.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(4);
            if (cnt_q != CW'(MEM_WORDS))
                cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                    eill_d  = 1'b0;
                    eovf_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                // Only a LOAD-state write can run out of space without fld_last.
                if (we_q && (cnt_q == CW'(MEM_WORDS - 1))) begin
                    eovf_d  = 1'b1;
                    state_d = ST_ERR;
                end
                if (accept) begin
                    if (pk_illegal) begin
                        eill_d  = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = pk_word;
                        if (fld_last)
                            state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (we_q)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; async reset abandons any load and kills a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            eill_q  <= 1'b0;
            eovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            eill_q  <= eill_d;
            eovf_q  <= eovf_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign word_count   = cnt_q;
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign cpu_rst_n    = (state_q == ST_DONE);
    assign err_illegal  = eill_q;
    assign err_overflow = eovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (MEM_WORDS=4 to reach overflow).
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        fld_valid;
    logic        fld_ready;
    logic [6:0]  fld_op;
    logic [4:0]  fld_rd, fld_rs1, fld_rs2;
    logic [2:0]  fld_f3;
    logic        fld_f7b5;
    logic [31:0] fld_imm;
    logic        fld_last;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  word_count;
    logic        busy, done, err_illegal, err_overflow, cpu_rst_n;

    int total = 0;
    int bad   = 0;

    // write log captured on the falling edge
    int          nw = 0;
    int          cyc = 0;
    logic [31:0] wa [16];
    logic [31:0] wd [16];
    int          wc [16];

    instr_encoder_loader #(.MEM_WORDS(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fld_valid(fld_valid), .fld_ready(fld_ready),
        .fld_op(fld_op), .fld_rd(fld_rd), .fld_rs1(fld_rs1), .fld_rs2(fld_rs2),
        .fld_f3(fld_f3), .fld_f7b5(fld_f7b5), .fld_imm(fld_imm), .fld_last(fld_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_overflow(err_overflow), .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1 && nw < 16) begin
            wa[nw] = imem_addr;
            wd[nw] = imem_wdata;
            wc[nw] = cyc;
            nw     = nw + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                          input logic [31:0] imm, input logic last);
        fld_op = op; fld_rd = rd; fld_rs1 = rs1; fld_rs2 = rs2;
        fld_f3 = f3; fld_f7b5 = f7b5; fld_imm = imm; fld_last = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_not_busy(output logic timeout);
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b0) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; fld_valid = 1'b0;
        bundle(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0, 1'b0);
        tick(); tick();
        total++; if ({imem_we, fld_ready, done, busy, err_illegal, err_overflow, cpu_rst_n} !== 7'b0)
            begin bad++; $display("FAIL reset_flags got=%b exp=0000000",
                {imem_we, fld_ready, done, busy, err_illegal, err_overflow, cpu_rst_n}); end
        total++; if (word_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", word_count); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        nw = 0;
        pulse_start();
        total++; if (fld_ready !== 1'b1 || busy !== 1'b1)
            begin bad++; $display("FAIL single_ready got=%b%b exp=11", fld_ready, busy); end
        bundle(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 1'b1);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", imem_we); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL single_addr got=%h exp=0", imem_addr); end
        total++; if (imem_wdata !== 32'h002081B3) begin bad++; $display("FAIL single_data got=%h exp=002081b3", imem_wdata); end
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL single_cpu_rst_drain got=%b exp=0", cpu_rst_n); end
        tick();
        total++; if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL single_done got=%b%b%b exp=110", done, cpu_rst_n, busy); end
        total++; if (word_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", word_count); end
        total++; if (imem_we !== 1'b0 || nw !== 1) begin bad++; $display("FAIL single_nwrites got=%0d exp=1 we=%b", nw, imem_we); end
    endtask

    task automatic test_back_to_back();
        logic to;
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        ed[0] = 32'h00812283; ed[1] = 32'h00512623; ed[2] = 32'hFE208CE3; ed[3] = 32'h010000EF;
        for (int i = 0; i < 4; i++) ea[i] = 32'(4 * i);
        nw = 0;
        pulse_start();
        fld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: bundle(7'b0000011, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8, 1'b0);
                1: bundle(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 32'd12, 1'b0);
                2: bundle(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd8, 1'b0);
                default: bundle(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd16, 1'b1);
            endcase
            total++; if (fld_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, fld_ready); end
            tick();
        end
        fld_valid = 1'b0;
        wait_not_busy(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%b exp=0", to); end
        total++; if (nw !== 4) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=4", nw); end
        for (int i = 0; i < 4 && i < nw; i++) begin
            total++; if (wa[i] !== ea[i] || wd[i] !== ed[i] || wc[i] !== wc[0] + i)
                begin bad++; $display("FAIL b2b_write%0d got=%h:%h@%0d exp=%h:%h@%0d",
                    i, wa[i], wd[i], wc[i], ea[i], ed[i], wc[0] + i); end
        end
        total++; if (done !== 1'b1 || word_count !== 3'd4 || err_overflow !== 1'b0)
            begin bad++; $display("FAIL b2b_end got=done%b cnt%0d ovf%b exp=done1 cnt4 ovf0",
                done, word_count, err_overflow); end
    endtask

    task automatic test_illegal();
        nw = 0;
        pulse_start();
        bundle(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd5, 1'b0);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        tick(); tick();
        total++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b exp=1", err_illegal); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || cpu_rst_n !== 1'b0 || fld_ready !== 1'b0)
            begin bad++; $display("FAIL ill_err_state got=%b%b%b%b exp=0000", busy, done, cpu_rst_n, fld_ready); end
        total++; if (nw !== 0 || word_count !== 3'd0) begin bad++; $display("FAIL ill_nowrite got=%0d/%0d exp=0/0", nw, word_count); end
        pulse_start();
        total++; if (err_illegal !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ill_restart got=%b%b exp=01", err_illegal, busy); end
        // addi x1,x0,-1 then an I-immediate just out of range (2048)
        bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        fld_valid = 1'b1;
        tick();
        bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b1);
        total++; if (imem_wdata !== 32'hFFF00093 || imem_we !== 1'b1)
            begin bad++; $display("FAIL ill_addi got=%h we=%b exp=fff00093 we=1", imem_wdata, imem_we); end
        tick();
        fld_valid = 1'b0;
        tick();
        total++; if (err_illegal !== 1'b1 || word_count !== 3'd1 || nw !== 1 || done !== 1'b0)
            begin bad++; $display("FAIL ill_range got=ill%b cnt%0d nw%0d done%b exp=ill1 cnt1 nw1 done0",
                err_illegal, word_count, nw, done); end
    endtask

    task automatic test_overflow();
        int acc = 0;
        nw = 0;
        pulse_start();
        fld_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (err_overflow === 1'b1) break;
            bundle(7'b0010011, 5'(acc + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'(acc), 1'b0);
            if (fld_ready === 1'b1) acc++;
            tick();
        end
        tick(); tick();
        fld_valid = 1'b0;
        total++; if (acc !== 4) begin bad++; $display("FAIL ovf_accepts got=%0d exp=4", acc); end
        total++; if (nw !== 4) begin bad++; $display("FAIL ovf_nwrites got=%0d exp=4", nw); end
        total++; if (err_overflow !== 1'b1 || err_illegal !== 1'b0 || word_count !== 3'd4)
            begin bad++; $display("FAIL ovf_flags got=ovf%b ill%b cnt%0d exp=ovf1 ill0 cnt4",
                err_overflow, err_illegal, word_count); end
        total++; if (cpu_rst_n !== 1'b0 || fld_ready !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL ovf_state got=%b%b%b exp=000", cpu_rst_n, fld_ready, done); end
        if (nw >= 4) begin
            total++; if (wa[3] !== 32'hC || wd[3] !== 32'h00300213)
                begin bad++; $display("FAIL ovf_last_write got=%h:%h exp=0000000c:00300213", wa[3], wd[3]); end
        end
    endtask

    task automatic test_reset_midload();
        logic to;
        nw = 0;
        pulse_start();
        fld_valid = 1'b1;
        bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 1'b0);
        tick();
        bundle(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2, 1'b0);
        tick();
        // second word pending now; kill it before it is written
        rst_n = 1'b0;
        fld_valid = 1'b0;
        #1;
        total++; if ({imem_we, busy, fld_ready, done, cpu_rst_n} !== 5'b0 || word_count !== 3'd0 || imem_addr !== 32'h0)
            begin bad++; $display("FAIL rstmid_outputs got=%b cnt%0d addr%h exp=00000 cnt0 addr0",
                {imem_we, busy, fld_ready, done, cpu_rst_n}, word_count, imem_addr); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (nw !== 1) begin bad++; $display("FAIL rstmid_nwrites got=%0d exp=1", nw); end
        nw = 0;
        pulse_start();
        bundle(7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b1);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        wait_not_busy(to);
        total++; if (to !== 1'b0 || nw !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'h123453B7)
            begin bad++; $display("FAIL rstmid_restart got=to%b nw%0d %h:%h exp=to0 nw1 00000000:123453b7",
                to, nw, wa[0], wd[0]); end
    endtask

    task automatic test_start_busy();
        logic to;
        nw = 0;
        pulse_start();
        fld_valid = 1'b1;
        bundle(7'b0110011, 5'd4, 5'd1, 5'd2, 3'd0, 1'b1, 32'h0, 1'b0);   // sub x4,x1,x2
        tick();
        start = 1'b1;
        bundle(7'b0010011, 5'd6, 5'd5, 5'd0, 3'b101, 1'b1, 32'd3, 1'b0); // srai x6,x5,3
        tick();
        bundle(7'b0010011, 5'd6, 5'd5, 5'd0, 3'b001, 1'b0, 32'd31, 1'b1); // slli x6,x5,31
        tick();
        fld_valid = 1'b0;
        tick();   // start still high through DRAIN
        start = 1'b0;
        wait_not_busy(to);
        total++; if (to !== 1'b0 || done !== 1'b1 || word_count !== 3'd3)
            begin bad++; $display("FAIL sb_end got=to%b done%b cnt%0d exp=to0 done1 cnt3", to, done, word_count); end
        total++; if (nw !== 3) begin bad++; $display("FAIL sb_nwrites got=%0d exp=3", nw); end
        if (nw == 3) begin
            total++; if (wa[0] !== 32'h0 || wa[1] !== 32'h4 || wa[2] !== 32'h8)
                begin bad++; $display("FAIL sb_addrs got=%h,%h,%h exp=0,4,8", wa[0], wa[1], wa[2]); end
            total++; if (wd[0] !== 32'h40208233 || wd[1] !== 32'h4032D313 || wd[2] !== 32'h01F29313)
                begin bad++; $display("FAIL sb_data got=%h,%h,%h exp=40208233,4032d313,01f29313",
                    wd[0], wd[1], wd[2]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_overflow();
        test_reset_midload();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Write-side counterpart of the control-unit decode path.
- Accepts decoded instruction fields (opcode, registers, funct, immediate) over a valid/ready handshake and packs them into RV32I machine words.
- Writes the packed words sequentially into instruction memory.
- Holds the monocycle core in reset while loading and releases it only after a complete, error-free program load.

Parameters:
- MEM_WORDS, 64, instruction-memory depth in 32-bit words; sets the load limit.
- ADDR_W, 32, width of the byte address driven to instruction memory.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new load.
- fld_valid  in  1  field bundle valid.
- fld_ready  out  1  encoder can accept a bundle.
- fld_op  in  7  opcode.
- fld_rd, fld_rs1, fld_rs2  in  5 each  register indices.
- fld_f3  in  3  funct3.
- fld_f7b5  in  1  funct7 bit 5 (instruction bit 30).
- fld_imm  in  32  signed immediate, byte offset for B/J formats.
- fld_last  in  1  marks the final bundle of the program.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  byte address of the write.
- imem_wdata  out  32  encoded word.
- word_count  out  $clog2(MEM_WORDS+1)  number of words written.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE.
- err_illegal  out  1  sticky: unsupported opcode or immediate out of range.
- err_overflow  out  1  sticky: MEM_WORDS words written without fld_last.
- cpu_rst_n  out  1  core reset; high only in DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0: imem_we, fld_ready, done, busy, errors, word_count, cpu_rst_n.
  - imem_addr = BASE_ADDR.
  - Applies mid-load too: any partial load is abandoned and no write occurs in the reset cycle.
- States: IDLE, LOAD, DRAIN, DONE, ERR.
- start is honoured in IDLE, DONE and ERR. It:
  - clears word_count and both error flags;
  - reloads the address to BASE_ADDR;
  - moves to LOAD.
- start is ignored in LOAD and DRAIN.
- fld_ready = (state==LOAD). A bundle is accepted on a rising edge where fld_valid && fld_ready.
- Supported opcodes and formats:
  - 0110011: R.
  - 0010011, 0000011, 1100111: I.
  - 0100011: S.
  - 1100011: B.
  - 0110111: U.
  - 1101111: J.
  - fld_f7b5 is used only for R-type and for I-type shifts (0010011 with f3=001 or 101); elsewhere it is ignored.
- Immediate range rules (violation = illegal):
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0; the word carries imm[31:12].
- Legal accept: encoded word is registered, so imem_we=1 in the cycle after the accept, with imem_addr = BASE_ADDR + 4*word_count.
  - Latency is 1 cycle; throughput is 1 word per cycle.
  - word_count and the address advance on the edge that ends the write cycle.
- Illegal accept: the handshake completes, but nothing is written.
  - err_illegal is set and the state goes to ERR.
  - A write still in flight from the previous accept completes normally.
- Accept with fld_last (legal): LOAD→DRAIN. The final write occurs in DRAIN, then DRAIN→DONE. done=1 and cpu_rst_n=1 from the first DONE cycle.
- Overflow: when the write bringing word_count to MEM_WORDS completes without fld_last seen, err_overflow is set and the state goes to ERR.
  - fld_ready is forced low in the cycle when word_count==MEM_WORDS-1 and a write is pending, so no extra bundle is taken.
  - If that pending word was the one marked fld_last, the load ends normally in DONE with word_count=MEM_WORDS and no overflow.
- In ERR, cpu_rst_n stays 0 and no further writes occur.
- Simultaneous errors: the illegal check applies to the bundle; overflow applies only to completed writes. Both flags may be set.
- word_count saturates at MEM_WORDS.

Decomposition:
- Shared package, used by both this block and the main decoder:
  - opcode constants (OP_R, OP_I_ALU, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL);
  - format enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J);
  - loader state enum.
- One combinational sub-module, instr_field_packer: maps fields to {word, format, illegal}. The FSM, address counter and output register stay in the top.

Test Plan:
- start; one bundle op=0110011, rd=3, rs1=1, rs2=2, f3=0, f7b5=0, last=1 -> next cycle imem_we=1, addr=0, wdata=0x002081B3; then DONE, cpu_rst_n=1, word_count=1.
- Back-to-back, valid held high: lw x5,8(x2); sw x5,12(x2); beq x1,x2,-8; jal x1,16 (last) -> writes on 4 consecutive cycles to addr 0, 4, 8, 12 with data 0x00812283, 0x00512623, 0xFE208CE3, 0x010000EF.
- beq with imm=5 (odd) -> no write; err_illegal=1; state ERR; cpu_rst_n stays 0; a later start clears err_illegal.
- MEM_WORDS=4; 5 bundles offered, none marked last -> exactly 4 writes; fifth bundle never accepted; err_overflow=1.
- rst_n asserted low for 1 cycle in the middle of a 3-word load -> outputs return to reset values immediately; no write in the reset cycle; start afterward restarts at BASE_ADDR.
- start pulsed while busy -> ignored; load completes with the original word_count sequence.
